mem_switch_nport: RTL and testbench
===================================

Name: mem_switch_nport

Overview:
- N-port generalisation of the two-port memory switch: NUM_PORTS channels share one synchronous storage array.
- Each port can request a write (store its din at an address) or a read (broadcast stored data to every port).
- A round-robin arbiter serialises requests with a valid/ready handshake.
- Ports with no read response see ring pass-through data from their neighbour.

Parameters:
- DATA_WIDTH, 16, width of each port's data bus.
- BYTE_ADDR_WIDTH, 8, address width; the array holds 2**BYTE_ADDR_WIDTH words of DATA_WIDTH.
- NUM_PORTS, 4, number of channels; legal values are 2 or more.
- PORT_W (localparam), $clog2(NUM_PORTS), width of the port index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_PORTS  per-port request strobe.
- req_wen  input  NUM_PORTS  per-port op: 1 = write, 0 = read.
- req_addr  input  NUM_PORTS*BYTE_ADDR_WIDTH  per-port address; port p occupies slice [p*AW +: AW].
- din  input  NUM_PORTS*DATA_WIDTH  per-port data in; port p occupies slice [p*DW +: DW].
- req_ready  output  NUM_PORTS  one-hot (or zero) grant; a request is accepted when valid&ready.
- dout  output  NUM_PORTS*DATA_WIDTH  per-port data out.
- dout_valid  output  NUM_PORTS  one-hot marker of the port whose read data is on dout.
- wr_pending  output  1  a write is latched and commits next edge.

Behaviour:
- Reset (rst=1 at an edge):
  - rr_ptr=0, wr_pending=0, rd_valid=0, dout_valid=0.
  - req_ready=0 while rst=1.
  - Array contents are not reset.
  - A latched write is discarded (never committed); an in-flight read response is suppressed.
- Eligibility:
  - With wr_pending=0, every port with req_valid=1 is eligible.
  - With wr_pending=1, only ports with req_valid=1 and req_wen=1 are eligible; reads stall.
- Arbitration (combinational):
  - Search eligible ports starting at rr_ptr, ascending, wrapping modulo NUM_PORTS.
  - The first hit g gets req_ready[g]=1; all other ready bits are 0.
  - At most one grant per cycle.
  - On any accept, rr_ptr <= (g+1) mod NUM_PORTS; with no accept, rr_ptr holds.
- Write path (two-stage, 1-cycle commit latency):
  - Accept at edge T latches wr_addr, wr_data=din[g] and sets wr_pending=1.
  - At edge T+1 the array is written. wr_pending then clears unless another write was accepted at T+1, in which case it reloads with the new write.
  - Back-to-back writes sustain one per cycle.
- Read path:
  - Read accepted at edge T (only possible with wr_pending=0) reads the array at T.
  - From T+1, for one cycle: dout[q]=read data for every q; dout_valid=one-hot(g).
  - No read/write hazard exists: reads are blocked while a write is pending, so a read always sees all earlier committed writes.
- Pass-through:
  - In any cycle without a read response, dout[p]=din[(p+1) mod NUM_PORTS] combinationally, and dout_valid=0.
  - For NUM_PORTS=2 this reduces to the left/right swap.
- Simultaneous events:
  - A read response and a new grant in the same cycle are independent.
  - Same-address writes from different ports are committed in grant order, so the last grant wins.
- Reads sustain one per cycle when no writes intervene.

Test Plan:
- NUM_PORTS=4, DW=16, AW=8 after reset, no requests, din={0x1111,0x2222,0x3333,0x4444} for ports 0..3 -> dout={0x2222,0x3333,0x4444,0x1111}, dout_valid=0, req_ready=0, wr_pending=0.
- Port1 writes addr 0x05 data 0xBEEF, accepted at edge T; port2 holds read 0x05 from T onward -> port2 ready=0 in cycle T+1, granted at T+2; cycle T+3 shows all dout=0xBEEF, dout_valid=4'b0100.
- All four ports hold read requests continuously from reset release -> grants 0,1,2,3,0,1 on consecutive cycles, each dout_valid one cycle after its grant.
- wr_pending=1, port0 read and port3 write both valid, rr_ptr=0 -> port3 granted, port0 stalls; port0 is granted the cycle after the write commits.
- Preload addr 0x10=0x1234; port0 write 0x10=0xAAAA accepted, rst asserted the following edge -> write discarded; a later read of 0x10 returns 0x1234; rr_ptr restarts at 0.
- Ports 1 and 2 both write addr 0x20 (0x0001, then 0x0002) in consecutive grants -> a subsequent read of 0x20 returns 0x0002.

Source files
------------

// File: rtl/mem_switch_nport_if.sv
// rtl/mem_switch_nport_if.sv - request/response bundle shared by all switch ports
// Master side drives requests and data in; slave side is the switch itself.
interface mem_switch_nport_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int BYTE_ADDR_WIDTH = 8,
  parameter int NUM_PORTS       = 4
);
  logic [NUM_PORTS-1:0]                 req_valid;
  logic [NUM_PORTS-1:0]                 req_wen;
  logic [NUM_PORTS*BYTE_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]      din;
  logic [NUM_PORTS-1:0]                 req_ready;
  logic [NUM_PORTS*DATA_WIDTH-1:0]      dout;
  logic [NUM_PORTS-1:0]                 dout_valid;
  logic                                 wr_pending;

  modport master (
    output req_valid, req_wen, req_addr, din,
    input  req_ready, dout, dout_valid, wr_pending
  );

  modport slave (
    input  req_valid, req_wen, req_addr, din,
    output req_ready, dout, dout_valid, wr_pending
  );
endinterface

// File: rtl/mem_switch_nport.sv
// rtl/mem_switch_nport.sv - N-port round-robin switch onto one synchronous storage array
// Writes commit one edge after accept; reads broadcast to every port for one cycle.
module mem_switch_nport #(
  parameter int DATA_WIDTH      = 16,
  parameter int BYTE_ADDR_WIDTH = 8,
  parameter int NUM_PORTS       = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_switch_nport_if.slave   bus
);
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int DW     = DATA_WIDTH;
  localparam int AW     = BYTE_ADDR_WIDTH;
  localparam int DEPTH  = 1 << AW;

  logic [DW-1:0]        mem_q [DEPTH];

  logic [PORT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                 wr_pending_q, wr_pending_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [DW-1:0]        wr_data_q, wr_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [PORT_W-1:0]    rd_port_q, rd_port_d;
  logic [DW-1:0]        rd_data_q;

  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] grant;
  logic                 gnt_any;
  logic [PORT_W-1:0]    gnt_idx;
  logic [PORT_W-1:0]    cand;
  logic                 sel_wen;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_din;

  // A latched write blocks reads so a read can never observe a stale word.
  assign elig = bus.req_valid & (wr_pending_q ? bus.req_wen : {NUM_PORTS{1'b1}});

  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PORT_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
      if (!gnt_any && elig[cand]) begin
        gnt_any     = 1'b1;
        gnt_idx     = cand;
        grant[cand] = 1'b1;
      end
    end
    if (rst) begin
      grant   = '0;
      gnt_any = 1'b0;
    end
  end

  assign sel_wen  = bus.req_wen[gnt_idx];
  assign sel_addr = bus.req_addr[gnt_idx*AW +: AW];
  assign sel_din  = bus.din[gnt_idx*DW +: DW];

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    wr_pending_d = gnt_any & sel_wen;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_valid_d   = gnt_any & ~sel_wen;
    rd_port_d    = rd_port_q;
    if (gnt_any) begin
      rr_ptr_d  = (gnt_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      rd_port_d = gnt_idx;
      if (sel_wen) begin
        wr_addr_d = sel_addr;
        wr_data_d = sel_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      wr_pending_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_pending_q <= wr_pending_d;
      rd_valid_q   <= rd_valid_d;
    end
    wr_addr_q <= wr_addr_d;
    wr_data_q <= wr_data_d;
    rd_port_q <= rd_port_d;
  end

  // Array has no reset; a write latched just before reset is dropped here.
  always_ff @(posedge clk) begin
    if (!rst && wr_pending_q) begin
      mem_q[wr_addr_q] <= wr_data_q;
    end
    if (rd_valid_d) begin
      rd_data_q <= mem_q[sel_addr];
    end
  end

  for (genvar q = 0; q < NUM_PORTS; q++) begin : g_dout
    assign bus.dout[q*DW +: DW] = rd_valid_q ? rd_data_q
                                             : bus.din[((q + 1) % NUM_PORTS)*DW +: DW];
  end

  always_comb begin
    bus.dout_valid = '0;
    if (rd_valid_q) begin
      bus.dout_valid[rd_port_q] = 1'b1;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.wr_pending = wr_pending_q;
endmodule

// File: tb/tb_mem_switch_nport.sv
// tb/tb_mem_switch_nport.sv - directed plus randomized check of mem_switch_nport against a queue model
module tb_mem_switch_nport;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 8;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int port; logic [DW-1:0] data; } rsp_t;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  logic [DW-1:0] ref_mem [1 << AW];
  wr_t           wq[$];
  rsp_t          rq[$];
  int            rr;

  logic [N-1:0]    obs_ready;
  logic [N-1:0]    obs_dv;
  logic [N*DW-1:0] obs_dout;
  logic            obs_wp;

  mem_switch_nport_if #(.DATA_WIDTH(DW), .BYTE_ADDR_WIDTH(AW), .NUM_PORTS(N)) bus ();

  mem_switch_nport #(.DATA_WIDTH(DW), .BYTE_ADDR_WIDTH(AW), .NUM_PORTS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] w,
                      input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    int              g;
    logic [N-1:0]    exp_ready;
    logic [N-1:0]    exp_dv;
    logic [N*DW-1:0] exp_dout;
    wr_t             e;
    rsp_t            rs;
    @(negedge clk);
    rst           = r;
    bus.req_valid = v;
    bus.req_wen   = w;
    bus.req_addr  = a;
    bus.din       = d;
    #1;
    g         = -1;
    exp_ready = '0;
    if (!r) begin
      for (int i = 0; i < N; i++) begin
        int p;
        p = (rr + i) % N;
        if (g < 0 && v[p] && (wq.size() == 0 || w[p])) g = p;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_dv = '0;
    if (rq.size() != 0) begin
      exp_dout = {N{rq[0].data}};
      exp_dv[rq[0].port] = 1'b1;
    end else begin
      for (int p = 0; p < N; p++) exp_dout[p*DW +: DW] = d[((p + 1) % N)*DW +: DW];
    end
    obs_ready = bus.req_ready;
    obs_dv    = bus.dout_valid;
    obs_dout  = bus.dout;
    obs_wp    = bus.wr_pending;
    chk("m_ready", 64'(obs_ready), 64'(exp_ready));
    chk("m_dout", 64'(obs_dout), 64'(exp_dout));
    chk("m_dout_valid", 64'(obs_dv), 64'(exp_dv));
    chk("m_wr_pending", 64'(obs_wp), 64'(wq.size() != 0));
    @(posedge clk);
    rq.delete();
    if (r) begin
      wq.delete();
      rr = 0;
    end else begin
      while (wq.size() != 0) begin
        e = wq.pop_front();
        ref_mem[e.addr] = e.data;
      end
      if (g >= 0) begin
        rr = (g + 1) % N;
        if (w[g]) begin
          e.addr = a[g*AW +: AW];
          e.data = d[g*DW +: DW];
          wq.push_back(e);
        end else begin
          rs.port = g;
          rs.data = ref_mem[a[g*AW +: AW]];
          rq.push_back(rs);
        end
      end
    end
  endtask

  initial begin
    logic [N*DW-1:0] d0;
    logic [N*DW-1:0] dx;
    logic [N*AW-1:0] ax;
    tests  = 0;
    failed = 0;
    rr     = 0;
    rst    = 1'b1;
    bus.req_valid = '0;
    bus.req_wen   = '0;
    bus.req_addr  = '0;
    bus.din       = '0;

    step(1'b1, '0, '0, '0, '0);
    step(1'b1, '0, '0, '0, '0);
    chk("rst_ready", 64'(obs_ready), 64'h0);

    d0 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    step(1'b0, '0, '0, '0, d0);
    chk("idle_dout", 64'(obs_dout), 64'h1111_4444_3333_2222);
    chk("idle_dv", 64'(obs_dv), 64'h0);
    chk("idle_ready", 64'(obs_ready), 64'h0);
    chk("idle_wp", 64'(obs_wp), 64'h0);

    for (int i = 0; i < 64; i++) begin
      step(1'b0, 4'b0001, 4'b0001, 32'(i), 64'(16'(i * 257) ^ 16'h5A5A));
    end
    step(1'b0, 4'b0001, 4'b0001, 32'h10, 64'h1234);
    step(1'b0, '0, '0, '0, '0);

    dx = 64'h0000_0000_BEEF_0000;
    step(1'b0, 4'b0110, 4'b0010, 32'h0005_0500, dx);
    chk("beef_grant_wr", 64'(obs_ready), 64'b0010);
    step(1'b0, 4'b0100, 4'b0000, 32'h0005_0500, dx);
    chk("beef_stall", 64'(obs_ready), 64'h0);
    chk("beef_wp", 64'(obs_wp), 64'h1);
    step(1'b0, 4'b0100, 4'b0000, 32'h0005_0500, dx);
    chk("beef_grant_rd", 64'(obs_ready), 64'b0100);
    step(1'b0, '0, '0, '0, '0);
    chk("beef_dout", 64'(obs_dout), {4{16'hBEEF}});
    chk("beef_dv", 64'(obs_dv), 64'b0100);

    step(1'b0, 4'b0001, 4'b0001, 32'h10, 64'hAAAA);
    chk("disc_grant", 64'(obs_ready), 64'b0001);
    step(1'b1, '0, '0, '0, '0);
    step(1'b0, '0, '0, '0, '0);
    chk("disc_wp", 64'(obs_wp), 64'h0);

    for (int k = 0; k < 7; k++) begin
      step(1'b0, 4'hF, 4'h0, 32'h1010_1010, '0);
      chk("rr_grant", 64'(obs_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        chk("rr_dv", 64'(obs_dv), 64'(1 << ((k - 1) % 4)));
        chk("rr_dout", 64'(obs_dout), {4{16'h1234}});
      end
    end
    step(1'b0, '0, '0, '0, '0);

    step(1'b1, '0, '0, '0, '0);
    step(1'b0, 4'b1000, 4'b1000, 32'h3000_0000, 64'h5555_0000_0000_0000);
    chk("wp_first", 64'(obs_ready), 64'b1000);
    step(1'b0, 4'b1001, 4'b1000, 32'h3100_0030, 64'h6666_0000_0000_0000);
    chk("wp_wr_wins", 64'(obs_ready), 64'b1000);
    chk("wp_still", 64'(obs_wp), 64'h1);
    step(1'b0, 4'b0001, 4'b0000, 32'h0000_0030, '0);
    chk("wp_rd_stall", 64'(obs_ready), 64'h0);
    step(1'b0, 4'b0001, 4'b0000, 32'h0000_0030, '0);
    chk("wp_rd_grant", 64'(obs_ready), 64'b0001);
    step(1'b0, '0, '0, '0, '0);
    chk("wp_rd_dout", 64'(obs_dout), {4{16'h5555}});

    dx = 64'h0000_0002_0001_0000;
    step(1'b0, 4'b0110, 4'b0110, 32'h0020_2000, dx);
    chk("waw_first", 64'(obs_ready), 64'b0010);
    step(1'b0, 4'b0100, 4'b0100, 32'h0020_2000, dx);
    chk("waw_second", 64'(obs_ready), 64'b0100);
    step(1'b0, '0, '0, '0, '0);
    step(1'b0, 4'b0001, 4'b0000, 32'h20, '0);
    step(1'b0, '0, '0, '0, '0);
    chk("waw_dout", 64'(obs_dout), {4{16'h0002}});

    for (int k = 0; k < 400; k++) begin
      ax = $urandom & 32'h3F3F_3F3F;
      dx = {$urandom, $urandom};
      step(($urandom_range(0, 39) == 0), 4'($urandom), 4'($urandom), ax, dx);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
